mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter MEM_LAT, default 2, cycles from issue to read data valid; legal values are 1 to 15.
REQ-004 SHALL have port i_CLK  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_if_req  in  1  fetch request, held until o_if_done.
REQ-007 SHALL have port i_if_addr  in  ADDR_W  fetch address, stable while i_if_req is high.
REQ-008 SHALL have port i_flush  in  1  branch/jump flush; kills the pending fetch.
REQ-009 SHALL have port o_if_done  out  1  one-cycle fetch completion.
REQ-010 SHALL have port o_if_rdata  out  DATA_W  instruction word, valid with o_if_done.
REQ-011 SHALL have port i_dm_req  in  1  data request, held until o_dm_done.
REQ-012 SHALL have port i_dm_we  in  1  1=store, 0=load.
REQ-013 SHALL have port i_dm_addr  in  ADDR_W  data address.
REQ-014 SHALL have port i_dm_wdata  in  DATA_W  store data.
REQ-015 SHALL have port o_dm_done  out  1  one-cycle data completion.
REQ-016 SHALL have port o_dm_rdata  out  DATA_W  load data, valid with o_dm_done.
REQ-017 SHALL have memory ports o_mem_en (out, 1), o_mem_we (out, 1), o_mem_addr (out, ADDR_W), o_mem_wdata (out, DATA_W) and i_mem_rdata (in, DATA_W).
REQ-018 SHALL have port o_stall_if  out  1  freeze IF/ID.
REQ-019 SHALL have port o_stall_mem  out  1  freeze EX/MEM and earlier stages.

Function
REQ-020 SHALL implement the states IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE with any eligible request, the block SHALL assert o_mem_en for exactly that cycle (issue cycle T) and drive the granted requester's address, write enable and write data onto the memory port.
REQ-022 On issue, the latency counter SHALL load MEM_LAT-1, then decrement once per BUSY cycle.
REQ-023 In a BUSY state with counter==0 (cycle T+MEM_LAT), the block SHALL assert the granted requester's done signal, pass i_mem_rdata to that requester's rdata output, and return to IDLE; for a store, o_dm_rdata is don't-care.
REQ-024 The earliest next issue SHALL be cycle T+MEM_LAT+1, giving one access per MEM_LAT+1 cycles.
REQ-025 Arbitration SHALL give data priority when both requests arrive in IDLE.
REQ-026 When a data access completes while i_if_req is pending, the next grant SHALL go to fetch even if i_dm_req is high, using a one-bit last-grant register so neither requester starves.
REQ-027 o_mem_en, o_mem_we and o_if_done/o_dm_done SHALL be 0 in every cycle not named in REQ-021 and REQ-023.
REQ-028 o_stall_if SHALL equal i_if_req & ~o_if_done.
REQ-029 o_stall_mem SHALL equal i_dm_req & ~o_dm_done.
REQ-030 If i_flush is high in IDLE, no fetch SHALL issue that cycle; a data issue is still allowed.
REQ-031 If i_flush is high at any cycle of BUSY_I, a kill flag SHALL be set, the access SHALL run to completion, o_if_done SHALL be suppressed at completion, and the kill flag SHALL clear on return to IDLE.
REQ-032 A request deasserted mid-access SHALL have no effect; the access completes and its done pulse is still emitted.

Reset
REQ-033 While reset==0 at a clock edge, the state SHALL become IDLE and the counter, kill flag and last-grant register SHALL be cleared.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Reset mid-access SHALL abandon the access: no done pulse SHALL be emitted and a late i_mem_rdata SHALL be ignored.
REQ-036 The first issue after reset SHALL occur no earlier than the first cycle with reset==1.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state encoding enum, the MEM_LAT default and the grant-select constants (GNT_IF, GNT_DM).
REQ-038 The latency down-counter SHALL be sub-module lat_counter, with load, decrement and zero flag; everything else is one FSM in mem_port_arbiter.

Verification
REQ-039 Single fetch: MEM_LAT=2, if_req at T with addr 0x00400000 and mem returning 0x20010001 -> mem_en at T only, o_if_done at T+2 with rdata 0x20010001, stall_if high for T..T+1.
REQ-040 Collision: if_req and dm_req (load 0x10010000) both at T -> data issued at T and done at T+2; fetch issued at T+3 and done at T+5.
REQ-041 Fairness: dm_req held continuously and if_req pending -> grants alternate D, I, D, I; no requester waits more than 2*(MEM_LAT+1) cycles.
REQ-042 Flush: i_flush at T+1 of a fetch issued at T -> no o_if_done, state returns to IDLE at T+3, and the next fetch issues at T+3.
REQ-043 Store with MEM_LAT=1: dm_we=1, addr 0x10010004, wdata 0xDEADBEEF -> mem_en & mem_we at T with those values, o_dm_done at T+1.
REQ-044 Reset mid-access: reset=0 at T+1 of a data load -> no o_dm_done, all outputs 0 and state IDLE next cycle, and the request is re-served after reset is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding. IDLE is all-zero so a held-in-reset debug port reads 0.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  // Default cycles from issue to read data valid (legal range 1..15).
  localparam int MEM_LAT_DEF = 2;

  // Latency counter width; holds MEM_LAT-1 for the largest legal MEM_LAT.
  localparam int CNT_W = 4;

  // Last-grant register values.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline's IF/MEM stages, the arbiter and the single
// memory port.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until its one-cycle *_done pulse; the arbiter never back-pressures beyond
// the stall outputs. The memory port is fire-and-forget: o_mem_en marks the
// single issue cycle and i_mem_rdata is sampled exactly MEM_LAT cycles later.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              i_flush;
  logic              o_if_done;
  logic [DATA_W-1:0] o_if_rdata;
  // Data requester
  logic              i_dm_req;
  logic              i_dm_we;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [DATA_W-1:0] i_dm_wdata;
  logic              o_dm_done;
  logic [DATA_W-1:0] o_dm_rdata;
  // Memory port
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  // Pipeline stalls
  logic              o_stall_if;
  logic              o_stall_mem;

  // Arbiter side
  modport slave (
    input  i_if_req, i_if_addr, i_flush, i_dm_req, i_dm_we, i_dm_addr,
           i_dm_wdata, i_mem_rdata,
    output o_if_done, o_if_rdata, o_dm_done, o_dm_rdata, o_mem_en, o_mem_we,
           o_mem_addr, o_mem_wdata, o_stall_if, o_stall_mem
  );

  // Pipeline/memory side
  modport master (
    output i_if_req, i_if_addr, i_flush, i_dm_req, i_dm_we, i_dm_addr,
           i_dm_wdata, i_mem_rdata,
    input  o_if_done, o_if_rdata, o_dm_done, o_dm_rdata, o_mem_en, o_mem_we,
           o_mem_addr, o_mem_wdata, o_stall_if, o_stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access.
module lat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_CLK,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load on issue, count down while busy, park at zero.
  always_ff @(posedge i_CLK) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One access is in flight at a time; each takes MEM_LAT+1 cycles including
// the return to IDLE. Data wins a tie, except right after a data access,
// when a waiting fetch gets its turn.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              i_CLK,
  input  logic              reset,
  mem_port_arbiter_if.slave io_bus,
  output logic [1:0]        o_state
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] BUSY_I = ST_BUSY_I;
  localparam logic [1:0] BUSY_D = ST_BUSY_D;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  logic [1:0] r_state;
  logic       r_kill;
  logic       r_last_gnt;

  logic w_cnt_zero;
  logic w_if_ok;
  logic w_dm_ok;
  logic w_idle;
  logic w_busy_i;
  logic w_busy_d;
  logic w_pick_dm;
  logic w_issue_if;
  logic w_issue_dm;
  logic w_issue;
  logic w_if_done;
  logic w_dm_done;

  // Arbitration and completion decode; everything is gated by reset so the
  // block is silent while reset is held low.
  always_comb begin
    w_if_ok    = io_bus.i_if_req & ~io_bus.i_flush;
    w_dm_ok    = io_bus.i_dm_req;
    w_idle     = reset & (r_state == IDLE);
    w_busy_i   = reset & (r_state == BUSY_I);
    w_busy_d   = reset & (r_state == BUSY_D);
    // Data wins unless the previous grant was data and a fetch is waiting.
    w_pick_dm  = w_dm_ok & ~(w_if_ok & (r_last_gnt == GNT_DM));
    w_issue_dm = w_idle & w_pick_dm;
    w_issue_if = w_idle & w_if_ok & ~w_pick_dm;
    w_issue    = w_issue_dm | w_issue_if;
    // A flush in the completion cycle itself also kills the fetch.
    w_if_done  = w_busy_i & w_cnt_zero & ~r_kill & ~io_bus.i_flush;
    w_dm_done  = w_busy_d & w_cnt_zero;
  end

  // Main FSM: issue from IDLE, wait out the latency, return to IDLE.
  // r_last_gnt only remembers a data grant across back-to-back accesses; any
  // idle cycle clears it so fresh simultaneous requests still favour data.
  always_ff @(posedge i_CLK) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_last_gnt <= GNT_IF;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue_dm) begin
            r_state    <= BUSY_D;
            r_last_gnt <= GNT_DM;
          end else if (w_issue_if) begin
            r_state    <= BUSY_I;
            r_last_gnt <= GNT_IF;
          end else begin
            r_last_gnt <= GNT_IF;
          end
        end
        BUSY_I: begin
          if (io_bus.i_flush) begin
            r_kill <= 1'b1;
          end
          if (w_cnt_zero) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
          end
        end
        BUSY_D: begin
          if (w_cnt_zero) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  lat_counter #(.W(CNT_W)) u_lat (
    .i_CLK      (i_CLK),
    .reset      (reset),
    .i_load     (w_issue),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_busy_i | w_busy_d),
    .o_zero     (w_cnt_zero)
  );

  // Output drive: the memory port carries the granted request only in the
  // issue cycle, read data is forwarded only alongside its done pulse.
  always_comb begin
    io_bus.o_mem_en    = w_issue;
    io_bus.o_mem_we    = w_issue_dm & io_bus.i_dm_we;
    io_bus.o_mem_addr  = w_issue_dm ? io_bus.i_dm_addr :
                         (w_issue_if ? io_bus.i_if_addr : {ADDR_W{1'b0}});
    io_bus.o_mem_wdata = w_issue_dm ? io_bus.i_dm_wdata : {DATA_W{1'b0}};
    io_bus.o_if_done   = w_if_done;
    io_bus.o_if_rdata  = w_if_done ? io_bus.i_mem_rdata : {DATA_W{1'b0}};
    io_bus.o_dm_done   = w_dm_done;
    io_bus.o_dm_rdata  = w_dm_done ? io_bus.i_mem_rdata : {DATA_W{1'b0}};
    io_bus.o_stall_if  = reset & io_bus.i_if_req & ~w_if_done;
    io_bus.o_stall_mem = reset & io_bus.i_dm_req & ~w_dm_done;
    o_state            = reset ? r_state : IDLE;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checks
// DUT A (MEM_LAT=2) every cycle, directed cases pin cycle numbers by hand,
// and DUT B (MEM_LAT=1) covers the single-cycle-latency store.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT_A = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();
  logic [1:0] st_a, st_b;

  mem_port_arbiter #(.MEM_LAT(LAT_A)) dut_a (
    .i_CLK(clk), .reset(rst), .io_bus(ifa), .o_state(st_a)
  );
  mem_port_arbiter #(.MEM_LAT(1)) dut_b (
    .i_CLK(clk), .reset(rst), .io_bus(ifb), .o_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];       // expected issue addresses, in order
  logic [31:0] issue_addr_q[$];
  int          issue_cyc_q[$];
  int          if_done_q[$];
  logic [31:0] if_rdata_q[$];
  int          dm_done_q[$];
  int          stall_if_cnt = 0;

  // model state: one outstanding access with an absolute completion cycle
  bit m_busy = 0, m_is_dm = 0, m_load = 0, m_killed = 0, m_prev_dm = 0;
  int m_end = 0;

  bit          rd_fixed = 0;
  logic [31:0] rd_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT A with the model for the current cycle and log events.
  task automatic model_step();
    bit e_en, e_we, e_ifd, e_dmd, if_ok, dm_ok, take_if, take_dm, at_end;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_st;
    e_en = 0; e_we = 0; e_ifd = 0; e_dmd = 0; at_end = 0;
    e_addr = '0; e_wdata = '0; e_st = ST_IDLE;
    if (!rst) begin
      m_busy = 0; m_killed = 0; m_prev_dm = 0;
    end else if (!m_busy) begin
      if_ok   = ifa.i_if_req && !ifa.i_flush;
      dm_ok   = ifa.i_dm_req;
      take_if = if_ok && (!dm_ok || m_prev_dm);
      take_dm = dm_ok && !take_if;
      m_prev_dm = 0;
      if (take_if || take_dm) begin
        e_en    = 1;
        e_we    = take_dm && ifa.i_dm_we;
        e_addr  = take_dm ? ifa.i_dm_addr : ifa.i_if_addr;
        e_wdata = ifa.i_dm_wdata;
        m_busy  = 1; m_is_dm = take_dm; m_load = take_dm && !ifa.i_dm_we;
        m_end   = cyc + LAT_A; m_killed = 0;
      end
    end else begin
      if (!m_is_dm && ifa.i_flush) m_killed = 1;
      at_end = (cyc == m_end);
      e_st   = m_is_dm ? ST_BUSY_D : ST_BUSY_I;
      e_ifd  = at_end && !m_is_dm && !m_killed;
      e_dmd  = at_end && m_is_dm;
      if (at_end) begin m_busy = 0; m_prev_dm = m_is_dm; end
    end
    check("mem_en", ifa.o_mem_en, e_en);
    check("mem_we", ifa.o_mem_we, e_we);
    if (e_en) check("mem_addr", ifa.o_mem_addr, e_addr);
    if (e_we) check("mem_wdata", ifa.o_mem_wdata, e_wdata);
    check("if_done", ifa.o_if_done, e_ifd);
    check("dm_done", ifa.o_dm_done, e_dmd);
    if (e_ifd) check("if_rdata", ifa.o_if_rdata, ifa.i_mem_rdata);
    if (e_dmd && m_load) check("dm_rdata", ifa.o_dm_rdata, ifa.i_mem_rdata);
    if (!rst) begin
      check("rst_if_rdata", ifa.o_if_rdata, 0);
      check("rst_dm_rdata", ifa.o_dm_rdata, 0);
    end
    check("stall_if", ifa.o_stall_if, rst && ifa.i_if_req && !e_ifd);
    check("stall_mem", ifa.o_stall_mem, rst && ifa.i_dm_req && !e_dmd);
    check("state", st_a, e_st);
    if (ifa.o_mem_en) begin
      issue_cyc_q.push_back(cyc);
      issue_addr_q.push_back(ifa.o_mem_addr);
    end
    if (ifa.o_if_done) begin
      if_done_q.push_back(cyc);
      if_rdata_q.push_back(ifa.o_if_rdata);
    end
    if (ifa.o_dm_done) dm_done_q.push_back(cyc);
    if (ifa.o_stall_if) stall_if_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    ifa.i_mem_rdata = rd_fixed ? rd_val : (32'hC0DE_0000 | 32'(cyc));
  endtask

  task automatic wait_done(input bit is_if, input int budget);
    int n;
    int base;
    n = 0;
    base = is_if ? if_done_q.size() : dm_done_q.size();
    while (((is_if ? if_done_q.size() : dm_done_q.size()) == base) && (n < budget)) begin
      tick();
      n++;
    end
    check(is_if ? "if_done_timeout" : "dm_done_timeout", n < budget, 1);
  endtask

  // ---------------- directed stimulus ----------------
  int T, ib, fb, db, sb;

  initial begin
    ifa.i_if_req = 0; ifa.i_if_addr = '0; ifa.i_flush = 0;
    ifa.i_dm_req = 0; ifa.i_dm_we = 0; ifa.i_dm_addr = '0; ifa.i_dm_wdata = '0;
    ifa.i_mem_rdata = '0;
    ifb.i_if_req = 0; ifb.i_if_addr = '0; ifb.i_flush = 0;
    ifb.i_dm_req = 0; ifb.i_dm_we = 0; ifb.i_dm_addr = '0; ifb.i_dm_wdata = '0;
    ifb.i_mem_rdata = '0;
    rst = 0;
    @(posedge clk); #1;

    // Reset: requests held high must not leak out while reset is low.
    ifa.i_if_req = 1; ifa.i_dm_req = 1; ifa.i_if_addr = 32'h0040_0000;
    #1;
    check("rst_mem_en", ifa.o_mem_en, 0);
    check("rst_stall_if", ifa.o_stall_if, 0);
    check("rst_stall_mem", ifa.o_stall_mem, 0);
    check("rst_state", st_a, 0);
    tick(); tick();
    ifa.i_if_req = 0; ifa.i_dm_req = 0;
    rst = 1;
    tick();

    // Single fetch, LAT=2.
    ib = issue_cyc_q.size(); fb = if_done_q.size(); sb = stall_if_cnt;
    T = cyc;
    rd_fixed = 1; rd_val = 32'h2001_0001; ifa.i_mem_rdata = rd_val;
    ifa.i_if_req = 1; ifa.i_if_addr = 32'h0040_0000;
    exp_q.push_back(32'h0040_0000);
    wait_done(1, 10);
    ifa.i_if_req = 0; rd_fixed = 0;
    tick();
    check("single_issue_cyc", issue_cyc_q[ib], T);
    check("single_issue_cnt", issue_cyc_q.size() - ib, 1);
    check("single_done_cyc", if_done_q[fb], T + 2);
    check("single_rdata", if_rdata_q[fb], 32'h2001_0001);
    check("single_stall_cycles", stall_if_cnt - sb, 2);

    // Collision: data first, fetch right after.
    ib = issue_cyc_q.size(); fb = if_done_q.size(); db = dm_done_q.size();
    T = cyc;
    ifa.i_if_req = 1; ifa.i_if_addr = 32'h0040_0004;
    ifa.i_dm_req = 1; ifa.i_dm_we = 0; ifa.i_dm_addr = 32'h1001_0000;
    exp_q.push_back(32'h1001_0000); exp_q.push_back(32'h0040_0004);
    wait_done(0, 10);
    ifa.i_dm_req = 0;
    wait_done(1, 10);
    ifa.i_if_req = 0;
    tick();
    check("coll_dm_issue", issue_cyc_q[ib], T);
    check("coll_dm_done", dm_done_q[db], T + 2);
    check("coll_if_issue", issue_cyc_q[ib+1], T + 3);
    check("coll_if_done", if_done_q[fb], T + 5);

    // Fairness: both held, grants alternate D, I, D, I.
    ib = issue_cyc_q.size(); fb = if_done_q.size(); db = dm_done_q.size();
    T = cyc;
    ifa.i_if_req = 1; ifa.i_if_addr = 32'h0040_0008;
    ifa.i_dm_req = 1; ifa.i_dm_we = 0; ifa.i_dm_addr = 32'h1001_0008;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h1001_0008); exp_q.push_back(32'h0040_0008);
    end
    repeat (12) tick();
    ifa.i_if_req = 0; ifa.i_dm_req = 0;
    tick();
    for (int i = 0; i < 4; i++) check("fair_issue_cyc", issue_cyc_q[ib+i], T + 3*i);
    check("fair_issue_cnt", issue_cyc_q.size() - ib, 4);
    check("fair_if_dones", if_done_q.size() - fb, 2);
    check("fair_dm_dones", dm_done_q.size() - db, 2);

    // Flush during a fetch: killed, next fetch at T+3.
    ib = issue_cyc_q.size(); fb = if_done_q.size();
    T = cyc;
    ifa.i_if_req = 1; ifa.i_if_addr = 32'h0040_0010;
    exp_q.push_back(32'h0040_0010); exp_q.push_back(32'h0040_0020);
    tick();
    ifa.i_flush = 1; ifa.i_if_addr = 32'h0040_0020;
    tick();
    ifa.i_flush = 0;
    wait_done(1, 10);
    ifa.i_if_req = 0;
    tick();
    check("flush_issue0", issue_cyc_q[ib], T);
    check("flush_issue1", issue_cyc_q[ib+1], T + 3);
    check("flush_done_cyc", if_done_q[fb], T + 5);
    check("flush_done_cnt", if_done_q.size() - fb, 1);

    // Flush in IDLE blocks the fetch for that cycle only.
    ib = issue_cyc_q.size(); fb = if_done_q.size();
    T = cyc;
    ifa.i_if_req = 1; ifa.i_if_addr = 32'h0040_0030; ifa.i_flush = 1;
    exp_q.push_back(32'h0040_0030);
    tick();
    ifa.i_flush = 0;
    wait_done(1, 10);
    ifa.i_if_req = 0;
    tick();
    check("idleflush_issue", issue_cyc_q[ib], T + 1);
    check("idleflush_done", if_done_q[fb], T + 3);

    // Store with request dropped mid-access still completes.
    ib = issue_cyc_q.size(); db = dm_done_q.size();
    T = cyc;
    ifa.i_dm_req = 1; ifa.i_dm_we = 1; ifa.i_dm_addr = 32'h1001_000C;
    ifa.i_dm_wdata = 32'h1234_5678;
    exp_q.push_back(32'h1001_000C);
    tick();
    ifa.i_dm_req = 0; ifa.i_dm_we = 0;
    tick(); tick();
    check("drop_issue", issue_cyc_q[ib], T);
    check("drop_done", dm_done_q[db], T + 2);

    // Reset mid-load: abandoned, then re-served once reset releases.
    ib = issue_cyc_q.size(); db = dm_done_q.size();
    T = cyc;
    ifa.i_dm_req = 1; ifa.i_dm_we = 0; ifa.i_dm_addr = 32'h1001_0010;
    exp_q.push_back(32'h1001_0010); exp_q.push_back(32'h1001_0010);
    tick();
    rst = 0;
    #1;
    check("midrst_mem_en", ifa.o_mem_en, 0);
    check("midrst_dm_done", ifa.o_dm_done, 0);
    check("midrst_stall_mem", ifa.o_stall_mem, 0);
    tick();
    rst = 1;
    #1;
    check("midrst_state_idle", st_a, 0);
    wait_done(0, 10);
    ifa.i_dm_req = 0;
    tick();
    check("midrst_issue0", issue_cyc_q[ib], T);
    check("midrst_reissue", issue_cyc_q[ib+1], T + 2);
    check("midrst_done", dm_done_q[db], T + 4);
    check("midrst_done_cnt", dm_done_q.size() - db, 1);

    // DUT B, MEM_LAT=1 store.
    ifb.i_dm_req = 1; ifb.i_dm_we = 1; ifb.i_dm_addr = 32'h1001_0004;
    ifb.i_dm_wdata = 32'hDEAD_BEEF;
    #1;
    check("b_mem_en", ifb.o_mem_en, 1);
    check("b_mem_we", ifb.o_mem_we, 1);
    check("b_mem_addr", ifb.o_mem_addr, 32'h1001_0004);
    check("b_mem_wdata", ifb.o_mem_wdata, 32'hDEAD_BEEF);
    check("b_done_early", ifb.o_dm_done, 0);
    tick();
    #1;
    check("b_done", ifb.o_dm_done, 1);
    check("b_mem_en_busy", ifb.o_mem_en, 0);
    check("b_state", st_b, ST_BUSY_D);
    tick();
    ifb.i_dm_req = 0; ifb.i_dm_we = 0;
    #1;
    check("b_no_reissue", ifb.o_mem_en, 0);
    tick();

    // Final scoreboard drain: issued addresses in expected order.
    check("issue_total", issue_addr_q.size(), exp_q.size());
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("issue_addr", (k < issue_addr_q.size()) ? issue_addr_q[k] : 32'hFFFF_FFFF, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
